// File: rtl/piece_bag_generator.sv
// Tetris piece dealer: 7-bag randomizer fed by a free-running 16-bit Galois LFSR.
// Deals one 3-bit piece code per start/advance handshake into the next-piece queue.
module piece_bag_generator #(
    parameter logic [15:0] SEED     = 16'hACE1,
    parameter int          BAG_MODE = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        advance,
    input  logic        seed_load,
    input  logic [15:0] seed,
    output logic [2:0]  piece_out,
    output logic        valid,
    output logic [2:0]  bag_count
);

    typedef enum logic [1:0] {IDLE, DEAL, READY} state_t;

    state_t      state_q, state_d;
    logic [15:0] lfsr_q, lfsr_d, lfsr_step;
    logic [6:0]  mask_q, mask_d, mask_set;
    logic [2:0]  piece_q, piece_d;
    logic [2:0]  count_q, count_d;
    logic        valid_q, valid_d;
    logic [2:0]  cand, pick;
    logic [3:0]  idx;
    logic [7:0]  mask_ext;
    logic        found;
    logic        deal;

    assign lfsr_step = lfsr_q[0] ? ({1'b0, lfsr_q[15:1]} ^ 16'hB400) : {1'b0, lfsr_q[15:1]};
    assign cand      = (lfsr_q[2:0] == 3'd7) ? 3'd0 : lfsr_q[2:0];
    // Bit 7 is forced set so a stray index of 7 can never be chosen.
    assign mask_ext  = {1'b1, mask_q};

    // Scan forward from the random candidate for the first piece not yet dealt this bag.
    always_comb begin
        pick  = cand;
        found = 1'b0;
        idx   = 4'd0;
        if (BAG_MODE != 0) begin
            for (int k = 0; k < 7; k++) begin
                idx = {1'b0, cand} + 4'(k);
                if (idx >= 4'd7) begin
                    idx = idx - 4'd7;
                end
                if (!found && !mask_ext[idx[2:0]]) begin
                    pick  = idx[2:0];
                    found = 1'b1;
                end
            end
        end
    end

    assign mask_set = mask_q | (7'd1 << pick);

    always_comb begin
        state_d = state_q;
        lfsr_d  = lfsr_step;
        mask_d  = mask_q;
        piece_d = piece_q;
        count_d = count_q;
        valid_d = valid_q;
        deal    = 1'b0;
        if (seed_load) begin
            lfsr_d  = (seed == 16'h0000) ? SEED : seed;
            mask_d  = 7'd0;
            count_d = 3'd0;
            valid_d = 1'b0;
            piece_d = 3'd0;
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_d = DEAL;
                    end
                end
                DEAL: begin
                    deal    = 1'b1;
                    state_d = READY;
                end
                READY: begin
                    deal = advance;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
        if (deal) begin
            piece_d = pick;
            valid_d = 1'b1;
            count_d = count_q + 3'd1;
            if (BAG_MODE != 0) begin
                // The seventh piece empties the bag on the same edge it is dealt.
                if (mask_set == 7'h7F) begin
                    mask_d  = 7'd0;
                    count_d = 3'd0;
                end else begin
                    mask_d = mask_set;
                end
            end else if (count_q == 3'd6) begin
                count_d = 3'd0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            lfsr_q  <= SEED;
            mask_q  <= 7'd0;
            piece_q <= 3'd0;
            count_q <= 3'd0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            mask_q  <= mask_d;
            piece_q <= piece_d;
            count_q <= count_d;
            valid_q <= valid_d;
        end
    end

    assign piece_out = piece_q;
    assign valid     = valid_q;
    assign bag_count = count_q;

endmodule

// File: tb/tb_piece_bag_generator.sv
// Directed bench for piece_bag_generator: bag-mode DUT checked against a behavioural model,
// plus an independent-draw DUT checked for code range and distribution.
module tb_piece_bag_generator;

    logic        clk;
    logic        reset;
    logic        start;
    logic        advance;
    logic        seed_load;
    logic [15:0] seed;
    logic [2:0]  piece_out, piece_out0;
    logic        valid, valid0;
    logic [2:0]  bag_count, bag_count0;

    int vectors;
    int miscompares;

    // Behavioural reference for the bag-mode DUT
    int          m_state;
    logic [15:0] m_lfsr;
    logic [6:0]  m_mask;
    int          m_piece;
    int          m_valid;
    int          m_count;

    logic [2:0] seq_piece [0:69];
    logic [2:0] seq_bag   [0:69];
    logic [2:0] ref_seq   [0:13];
    logic [2:0] seed_seq  [0:13];
    int         hist      [0:6];
    logic [6:0] seen;

    piece_bag_generator #(.SEED(16'hACE1), .BAG_MODE(1)) dut (
        .clk(clk), .reset(reset), .start(start), .advance(advance),
        .seed_load(seed_load), .seed(seed),
        .piece_out(piece_out), .valid(valid), .bag_count(bag_count)
    );

    piece_bag_generator #(.SEED(16'hACE1), .BAG_MODE(0)) dut_draw (
        .clk(clk), .reset(reset), .start(start), .advance(advance),
        .seed_load(seed_load), .seed(seed),
        .piece_out(piece_out0), .valid(valid0), .bag_count(bag_count0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_state = 0;
        m_lfsr  = 16'hACE1;
        m_mask  = 7'd0;
        m_piece = 0;
        m_valid = 0;
        m_count = 0;
    endtask

    task automatic model_step();
        int  c;
        int  p;
        bit  do_deal;
        bit  fb;
        fb = m_lfsr[0];
        if (seed_load) begin
            m_lfsr  = (seed == 16'h0) ? 16'hACE1 : seed;
            m_mask  = 7'd0;
            m_count = 0;
            m_valid = 0;
            m_piece = 0;
            m_state = 0;
            return;
        end
        do_deal = (m_state == 1) || (m_state == 2 && advance);
        if (do_deal) begin
            c = int'(m_lfsr[2:0]);
            if (c == 7) c = 0;
            p = c;
            for (int off = 0; off < 7; off++) begin
                if (!m_mask[(c + off) % 7]) begin
                    p = (c + off) % 7;
                    break;
                end
            end
            m_piece = p;
            m_valid = 1;
            m_mask[p] = 1'b1;
            m_count++;
            if (m_mask == 7'h7F) begin
                m_mask  = 7'd0;
                m_count = 0;
            end
        end
        if (m_state == 0 && start) m_state = 1;
        else if (m_state == 1) m_state = 2;
        m_lfsr = m_lfsr >> 1;
        if (fb) m_lfsr = m_lfsr ^ 16'hB400;
    endtask

    task automatic apply_stimulus(input logic st, input logic adv, input logic sl, input logic [15:0] sd);
        start     = st;
        advance   = adv;
        seed_load = sl;
        seed      = sd;
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_output(input string tag);
        chk({tag, "_piece"}, {13'd0, piece_out}, 16'(m_piece));
        chk({tag, "_valid"}, {15'd0, valid}, 16'(m_valid));
        chk({tag, "_bag"}, {13'd0, bag_count}, 16'(m_count));
    endtask

    // From IDLE just after reset/seed_load: 4 idle edges, start, then n deals back to back.
    task automatic play(input int n);
        apply_stimulus(0, 0, 0, 16'h0);
        repeat (4) cycle();
        apply_stimulus(1, 0, 0, 16'h0);
        cycle();
        apply_stimulus(0, 0, 0, 16'h0);
        cycle();
        check_output("deal");
        seq_piece[0] = piece_out;
        seq_bag[0]   = bag_count;
        apply_stimulus(0, 1, 0, 16'h0);
        for (int k = 1; k < n; k++) begin
            cycle();
            check_output("deal");
            seq_piece[k] = piece_out;
            seq_bag[k]   = bag_count;
        end
        apply_stimulus(0, 0, 0, 16'h0);
    endtask

    task automatic check_perm(input string tag, input int first);
        seen = 7'd0;
        for (int k = first; k < first + 7; k++) begin
            if (seq_piece[k] != 3'd7) seen[seq_piece[k]] = 1'b1;
        end
        chk(tag, {9'd0, seen}, 16'h007F);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        apply_stimulus(0, 0, 0, 16'h0);
        reset = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_piece", {13'd0, piece_out}, 16'd0);
        chk("rst_valid", {15'd0, valid}, 16'd0);
        chk("rst_bag", {13'd0, bag_count}, 16'd0);
        reset = 1'b0;

        // 70 pieces straight after reset: seven-piece permutations, bag_count 1..6,0
        play(70);
        chk("t1_first_piece", {13'd0, seq_piece[0]}, 16'd0);
        chk("t1_second_piece", {13'd0, seq_piece[1]}, 16'd3);
        for (int k = 0; k < 70; k++) begin
            chk("t1_bag_count", {13'd0, seq_bag[k]}, 16'((k + 1) % 7));
            chk("t1_code_range", {15'd0, seq_piece[k] < 3'd7}, 16'd1);
        end
        for (int g = 0; g < 10; g++) check_perm("t1_perm", g * 7);
        for (int k = 0; k < 14; k++) ref_seq[k] = seq_piece[k];

        // seed 0 reproduces the reset seed; a fixed seed reproduces itself
        apply_stimulus(0, 0, 1, 16'h0000);
        cycle();
        chk("t2_seed0_valid", {15'd0, valid}, 16'd0);
        play(14);
        for (int k = 0; k < 14; k++) chk("t2_seed0_seq", {13'd0, seq_piece[k]}, {13'd0, ref_seq[k]});
        apply_stimulus(0, 0, 1, 16'h1234);
        cycle();
        play(14);
        for (int k = 0; k < 14; k++) seed_seq[k] = seq_piece[k];
        apply_stimulus(0, 0, 1, 16'h1234);
        cycle();
        play(14);
        for (int k = 0; k < 14; k++) chk("t2_seed1234_seq", {13'd0, seq_piece[k]}, {13'd0, seed_seq[k]});

        // Holding in READY changes nothing, and the following bag is still complete
        for (int k = 0; k < 100; k++) begin
            cycle();
            check_output("t3_hold");
        end
        apply_stimulus(0, 1, 0, 16'h0);
        for (int k = 0; k < 7; k++) begin
            cycle();
            check_output("t3_bag");
            seq_piece[k] = piece_out;
        end
        apply_stimulus(0, 0, 0, 16'h0);
        check_perm("t3_perm_after_hold", 0);

        // seed_load after a partial bag throws the bag away
        apply_stimulus(0, 1, 0, 16'h0);
        repeat (3) cycle();
        chk("t4_partial_bag", {13'd0, bag_count}, 16'd3);
        apply_stimulus(0, 0, 1, 16'hBEEF);
        cycle();
        chk("t4_sl_valid", {15'd0, valid}, 16'd0);
        chk("t4_sl_bag", {13'd0, bag_count}, 16'd0);
        chk("t4_sl_piece", {13'd0, piece_out}, 16'd0);
        play(7);
        check_perm("t4_perm", 0);

        // advance alongside start or during DEAL is ignored; seed_load beats advance
        apply_stimulus(0, 0, 1, 16'h0042);
        cycle();
        apply_stimulus(1, 1, 0, 16'h0);
        cycle();
        chk("t5_deal_valid", {15'd0, valid}, 16'd0);
        apply_stimulus(0, 1, 0, 16'h0);
        cycle();
        apply_stimulus(0, 0, 0, 16'h0);
        cycle();
        chk("t5_one_piece_bag", {13'd0, bag_count}, 16'd1);
        chk("t5_one_piece_valid", {15'd0, valid}, 16'd1);
        check_output("t5_model");
        apply_stimulus(0, 1, 1, 16'h5555);
        cycle();
        chk("t5_sl_adv_valid", {15'd0, valid}, 16'd0);
        chk("t5_sl_adv_bag", {13'd0, bag_count}, 16'd0);
        apply_stimulus(0, 1, 0, 16'h0);
        cycle();
        chk("t5_idle_adv_valid", {15'd0, valid}, 16'd0);
        chk("t5_idle_adv_bag", {13'd0, bag_count}, 16'd0);
        apply_stimulus(0, 0, 0, 16'h0);

        // Reset between edges while READY clears outputs without a clock
        apply_stimulus(1, 0, 0, 16'h0);
        cycle();
        apply_stimulus(0, 1, 0, 16'h0);
        repeat (3) cycle();
        apply_stimulus(0, 0, 0, 16'h0);
        chk("t6_ready_valid", {15'd0, valid}, 16'd1);
        model_step();
        @(posedge clk);
        #2 reset = 1'b1;
        model_reset();
        #1;
        chk("t6_async_piece", {13'd0, piece_out}, 16'd0);
        chk("t6_async_valid", {15'd0, valid}, 16'd0);
        chk("t6_async_bag", {13'd0, bag_count}, 16'd0);
        @(negedge clk);
        reset = 1'b0;

        // Independent draws: 1400 codes, all legal, every code well represented
        for (int c = 0; c < 7; c++) hist[c] = 0;
        apply_stimulus(1, 0, 0, 16'h0);
        cycle();
        apply_stimulus(0, 0, 0, 16'h0);
        cycle();
        apply_stimulus(0, 1, 0, 16'h0);
        for (int k = 0; k < 1400; k++) begin
            if (k > 0) cycle();
            chk("t6_draw_range", {15'd0, piece_out0 < 3'd7}, 16'd1);
            if (piece_out0 < 3'd7) hist[piece_out0]++;
        end
        apply_stimulus(0, 0, 0, 16'h0);
        for (int c = 0; c < 7; c++) begin
            vectors++;
            assert (hist[c] >= 120) else begin
                miscompares++;
                $error("[TB] FAIL t6_hist code=%0d observed=%0d expected>=120", c, hist[c]);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
